// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM (lw, sw, R-type, I-type ALU, beq, jal).
// Define MC_ILLEGAL_TRAP_EN to trap unlisted opcodes instead of treating them as NOPs.
module multicycle_controller (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [6:0] i_OpCode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  input  logic       i_Zero,
  input  logic       i_MemReady,
  output logic       o_PCWrite,
  output logic       o_AdrSrc,
  output logic       o_MemWrite,
  output logic       o_IRWrite,
  output logic [1:0] o_ResultSrc,
  output logic       o_RegWrite,
  output logic [1:0] o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic [2:0] o_ALUControl,
  output logic [1:0] o_ImmSrc,
  output logic [3:0] o_State,
  output logic       o_Illegal
);

  // state    | meaning
  // FETCH    | read instruction, PC+4 on MemReady
  // DECODE   | register read, PC+imm target precompute
  // MEMADR   | base + offset for lw/sw
  // MEMREAD  | data load, wait MemReady
  // MEMWB    | load data to register file
  // MEMWRITE | data store, wait MemReady
  // EXECR    | R-type ALU op
  // EXECI    | I-type ALU op
  // ALUWB    | ALU result to register file
  // BEQ      | compare, branch on zero
  // JAL      | jump, link address computed
  // TRAP     | illegal opcode, left only by reset
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     state_q, state_d;
  logic       pc_update, branch;
  logic [1:0] alu_op;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_update   = 1'b0;
    branch      = 1'b0;
    alu_op      = 2'b00;
    o_AdrSrc    = 1'b0;
    o_MemWrite  = 1'b0;
    o_IRWrite   = 1'b0;
    o_ResultSrc = 2'b00;
    o_RegWrite  = 1'b0;
    o_ALUSrcA   = 2'b00;
    o_ALUSrcB   = 2'b00;
    case (state_q)
      S_FETCH: begin
        o_ALUSrcB   = 2'b10;
        o_ResultSrc = 2'b10;
        o_IRWrite   = i_MemReady;
        pc_update   = i_MemReady;
        if (i_MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        o_ALUSrcA = 2'b01;
        o_ALUSrcB = 2'b01;
        case (i_OpCode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        o_ALUSrcA = 2'b10;
        o_ALUSrcB = 2'b01;
        state_d   = i_OpCode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        o_AdrSrc = 1'b1;
        if (i_MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        o_ResultSrc = 2'b01;
        o_RegWrite  = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        o_AdrSrc   = 1'b1;
        o_MemWrite = 1'b1;
        if (i_MemReady) state_d = S_FETCH;
      end
      S_EXECR: begin
        o_ALUSrcA = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        o_ALUSrcA = 2'b10;
        o_ALUSrcB = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        o_RegWrite = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        o_ALUSrcA = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        o_ALUSrcA = 2'b01;
        o_ALUSrcB = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:  state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    o_ALUControl = 3'b000;
    case (alu_op)
      2'b01: o_ALUControl = 3'b001;
      2'b10: begin
        case (i_funct3)
          3'b000:  o_ALUControl = (i_OpCode[5] & i_funct7_5) ? 3'b001 : 3'b000;
          3'b010:  o_ALUControl = 3'b101;
          3'b110:  o_ALUControl = 3'b011;
          3'b111:  o_ALUControl = 3'b010;
          default: o_ALUControl = 3'b000;
        endcase
      end
      default: o_ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (i_OpCode)
      OP_SW:   o_ImmSrc = 2'b01;
      OP_BEQ:  o_ImmSrc = 2'b10;
      OP_JAL:  o_ImmSrc = 2'b11;
      default: o_ImmSrc = 2'b00;
    endcase
  end

  assign o_PCWrite = pc_update | (branch & i_Zero);
  assign o_State   = state_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign o_Illegal = (state_q == S_TRAP);
`else
  assign o_Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Instruction-level bench for multicycle_controller: each instruction is expanded
// into its expected per-cycle state trace and checked against a per-state control table.
module tb_multicycle_controller;

  logic       clk, rst;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7, zero, mr;
  logic       pcw, adr, mw, irw, rw, ill;
  logic [1:0] rsrc, srca, srcb, imm;
  logic [2:0] aluc;
  logic [3:0] st;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  multicycle_controller dut (
    .i_Clk(clk), .i_Reset(rst), .i_OpCode(op), .i_funct3(f3), .i_funct7_5(f7),
    .i_Zero(zero), .i_MemReady(mr), .o_PCWrite(pcw), .o_AdrSrc(adr),
    .o_MemWrite(mw), .o_IRWrite(irw), .o_ResultSrc(rsrc), .o_RegWrite(rw),
    .o_ALUSrcA(srca), .o_ALUSrcB(srcb), .o_ALUControl(aluc), .o_ImmSrc(imm),
    .o_State(st), .o_Illegal(ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected control word {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,RegWrite,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,Illegal}
  function automatic logic [17:0] exp_ctrl(input int s, input logic [6:0] o, input logic [2:0] fn3,
                                           input logic fn7, input logic z, input logic ready);
    logic a = 0, m = 0, i = 0, w = 0, pu = 0, br = 0, il = 0;
    logic [1:0] r = 0, sa = 0, sb = 0, aop = 0, im;
    logic [2:0] ac;
    case (s)
      0:  begin sb = 2; r = 2; i = ready; pu = ready; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  a = 1;
      4:  begin r = 1; w = 1; end
      5:  begin a = 1; m = 1; end
      6:  begin sa = 2; aop = 2; end
      7:  begin sa = 2; sb = 1; aop = 2; end
      8:  w = 1;
      9:  begin sa = 2; aop = 1; br = 1; end
      10: begin sa = 1; sb = 2; pu = 1; end
      11: il = 1;
      default: ;
    endcase
    if (aop == 0) ac = 0;
    else if (aop == 1) ac = 1;
    else if (fn3 == 0) ac = (o[5] && fn7) ? 3'd1 : 3'd0;
    else if (fn3 == 2) ac = 5;
    else if (fn3 == 6) ac = 3;
    else if (fn3 == 7) ac = 2;
    else ac = 0;
    im = (o == SW) ? 2'd1 : (o == BQ) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
    return {pu | (br & z), a, m, i, r, w, sa, sb, ac, im, il};
  endfunction

  function automatic logic [17:0] got_ctrl();
    return {pcw, adr, mw, irw, rsrc, rw, srca, srcb, aluc, imm, ill};
  endfunction

  task automatic check_cycle(input string tag, input int s);
    check_val({tag, "_state"}, 32'(st), 32'(s));
    check_val({tag, "_ctrl"}, 32'(got_ctrl()), 32'(exp_ctrl(s, op, f3, f7, zero, mr)));
  endtask

  // Builds the expected trace for one instruction and steps through it.
  // abort_at >= 0 pulses reset asynchronously in that cycle of the trace.
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] fn3, input logic fn7,
                           input logic z, input int wfetch, input int wmem, input int abort_at);
    int  sq[$];
    bit  rq[$];
    for (int k = 0; k < wfetch; k++) begin sq.push_back(0); rq.push_back(0); end
    sq.push_back(0); rq.push_back(1);
    sq.push_back(1); rq.push_back(1'($urandom));
    case (o)
      LW: begin
        sq.push_back(2); rq.push_back(1'($urandom));
        for (int k = 0; k < wmem; k++) begin sq.push_back(3); rq.push_back(0); end
        sq.push_back(3); rq.push_back(1);
        sq.push_back(4); rq.push_back(1'($urandom));
      end
      SW: begin
        sq.push_back(2); rq.push_back(1'($urandom));
        for (int k = 0; k < wmem; k++) begin sq.push_back(5); rq.push_back(0); end
        sq.push_back(5); rq.push_back(1);
      end
      RT: begin sq.push_back(6); rq.push_back(1'($urandom)); sq.push_back(8); rq.push_back(1'($urandom)); end
      IT: begin sq.push_back(7); rq.push_back(1'($urandom)); sq.push_back(8); rq.push_back(1'($urandom)); end
      BQ: begin sq.push_back(9); rq.push_back(1'($urandom)); end
      JL: begin sq.push_back(10); rq.push_back(1'($urandom)); sq.push_back(8); rq.push_back(1'($urandom)); end
      default: begin
`ifdef MC_ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++) begin sq.push_back(11); rq.push_back(1'($urandom)); end
        abort_at = sq.size() - 1;
`endif
      end
    endcase
    for (int c = 0; c < sq.size(); c++) begin
      @(negedge clk);
      op = o; f3 = fn3; f7 = fn7; zero = z; mr = rq[c];
      #1;
      check_cycle(tag, sq[c]);
      if (c == abort_at) begin
        mr = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_cycle({tag, "_rst_async"}, 0);
        @(negedge clk);
        check_cycle({tag, "_rst_hold"}, 0);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          #1;
          check_cycle({tag, "_post_rst"}, 0);
        end
        return;
      end
    end
  endtask

  logic [6:0] ops [8];

  initial begin
    ops = '{LW, SW, RT, IT, BQ, JL, 7'b1111111, 7'b0000000};
    rst = 1'b1; op = 7'd0; f3 = 3'd0; f7 = 1'b0; zero = 1'b0; mr = 1'b0;
    @(negedge clk);
    #1 check_cycle("reset_gated", 0);
    mr = 1'b1;
    #1 check_cycle("reset_ready", 0);
    @(negedge clk);
    check_cycle("reset_hold", 0);
    mr = 1'b0;
    rst = 1'b0;

    run_instr("lw",        LW,         3'd0, 1'b0, 1'b0, 0, 0, -1);
    run_instr("sw_wait3",  SW,         3'd2, 1'b0, 1'b0, 1, 3, -1);
    run_instr("beq_taken", BQ,         3'd0, 1'b0, 1'b1, 0, 0, -1);
    run_instr("beq_not",   BQ,         3'd0, 1'b0, 1'b0, 0, 0, -1);
    run_instr("sub",       RT,         3'd0, 1'b1, 1'b0, 0, 0, -1);
    run_instr("addi_f7",   IT,         3'd0, 1'b1, 1'b0, 0, 0, -1);
    run_instr("jal",       JL,         3'd0, 1'b0, 1'b1, 0, 0, -1);
    run_instr("illegal",   7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, -1);
    run_instr("lw_abort",  LW,         3'd0, 1'b0, 1'b0, 0, 2, 3);
    run_instr("lw_after",  LW,         3'd0, 1'b0, 1'b0, 0, 1, -1);

    for (int n = 0; n < 80; n++) begin
      int idx;
      idx = $urandom_range(0, 7);
      run_instr("rand", ops[idx], 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    @(negedge clk);
    mr = 1'b0;
    #1 check_cycle("final_fetch", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
